// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch/decode/execute/halt control FSM that owns the program
// counter and the retired-instruction counter, and steers the next-PC mux.
module pc_sequencer #(
    parameter int                    DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = {DATA_WIDTH{1'b0}}
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [5:0]            opcode,
    input  logic                  mem_ready,
    input  logic                  halt_req,
    input  logic                  resume,
    input  logic [DATA_WIDTH-1:0] next_pc,
    output logic [DATA_WIDTH-1:0] pc,
    output logic [DATA_WIDTH-1:0] pc_inc,
    output logic [1:0]            bm_select,
    output logic                  beq,
    output logic                  bneq,
    output logic                  ir_load,
    output logic                  pc_write,
    output logic                  busy,
    output logic                  halted,
    output logic [DATA_WIDTH-1:0] retired_count
);

    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_DECODE  = 2'd1,
        ST_EXECUTE = 2'd2,
        ST_HALTED  = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        CL_SEQ  = 3'd0,
        CL_BEQ  = 3'd1,
        CL_BNE  = 3'd2,
        CL_JMP  = 3'd3,
        CL_JR   = 3'd4,
        CL_HALT = 3'd5
    } op_class_t;

    // Map a raw opcode onto the small class set the EXECUTE stage acts on.
    function automatic op_class_t decode_op(input logic [5:0] op);
        op_class_t cls;
        case (op)
            6'h04:   cls = CL_BEQ;
            6'h05:   cls = CL_BNE;
            6'h02:   cls = CL_JMP;
            6'h08:   cls = CL_JR;
            6'h3F:   cls = CL_HALT;
            default: cls = CL_SEQ;
        endcase
        return cls;
    endfunction

    state_t                  state_r;
    state_t                  state_next_s;
    op_class_t               class_r;
    logic [DATA_WIDTH-1:0]   pc_r;
    logic [DATA_WIDTH-1:0]   retired_r;
    logic                    ir_load_s;
    logic                    pc_write_s;
    logic                    retire_s;
    logic [1:0]              bm_select_s;
    logic                    beq_s;
    logic                    bneq_s;

    // State, decoded class, PC and retire counter; reset wins over any update
    // so a reset landing on EXECUTE suppresses that cycle's retire.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r   <= ST_FETCH;
            class_r   <= CL_SEQ;
            pc_r      <= RESET_VECTOR;
            retired_r <= {DATA_WIDTH{1'b0}};
        end else begin
            state_r <= state_next_s;
            if (state_r == ST_DECODE) begin
                class_r <= decode_op(opcode);
            end
            if (pc_write_s) begin
                pc_r <= next_pc;
            end
            if (retire_s) begin
                retired_r <= retired_r + DATA_WIDTH'(1);
            end
        end
    end

    // Next-state and per-state control decode; everything idles outside EXECUTE.
    always_comb begin
        state_next_s = state_r;
        ir_load_s    = 1'b0;
        pc_write_s   = 1'b0;
        retire_s     = 1'b0;
        bm_select_s  = 2'b00;
        beq_s        = 1'b0;
        bneq_s       = 1'b0;
        case (state_r)
            ST_FETCH: begin
                if (mem_ready) begin
                    ir_load_s    = 1'b1;
                    state_next_s = ST_DECODE;
                end else begin
                    state_next_s = ST_FETCH;
                end
            end
            ST_DECODE: begin
                state_next_s = ST_EXECUTE;
            end
            ST_EXECUTE: begin
                retire_s = 1'b1;
                case (class_r)
                    CL_BEQ: begin
                        bm_select_s = 2'b01;
                        beq_s       = 1'b1;
                    end
                    CL_BNE: begin
                        bm_select_s = 2'b01;
                        bneq_s      = 1'b1;
                    end
                    CL_JMP:  bm_select_s = 2'b10;
                    CL_JR:   bm_select_s = 2'b11;
                    CL_HALT: bm_select_s = 2'b00;
                    default: bm_select_s = 2'b00;
                endcase
                // A halt opcode retires but leaves the PC where it is.
                if (class_r == CL_HALT) begin
                    pc_write_s = 1'b0;
                end else begin
                    pc_write_s = 1'b1;
                end
                if ((class_r == CL_HALT) || halt_req) begin
                    state_next_s = ST_HALTED;
                end else begin
                    state_next_s = ST_FETCH;
                end
            end
            ST_HALTED: begin
                if (resume) begin
                    state_next_s = ST_FETCH;
                end else begin
                    state_next_s = ST_HALTED;
                end
            end
            default: begin
                state_next_s = ST_FETCH;
            end
        endcase
    end

    // Strobes are forced quiet while reset is held low.
    assign ir_load       = ir_load_s & reset_n;
    assign pc_write      = pc_write_s & reset_n;
    assign bm_select     = reset_n ? bm_select_s : 2'b00;
    assign beq           = beq_s & reset_n;
    assign bneq          = bneq_s & reset_n;
    assign halted        = reset_n & (state_r == ST_HALTED);
    assign busy          = (state_r != ST_HALTED);
    assign pc            = pc_r;
    assign pc_inc        = pc_r + DATA_WIDTH'(1);
    assign retired_count = retired_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: stimulus queues expected EXECUTE
// responses, a monitor pops them whenever pc_write is presented.
module tb_pc_sequencer;

    localparam int           W  = 12;
    localparam logic [W-1:0] RV = 12'h100;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [5:0]   opcode;
    logic         mem_ready;
    logic         halt_req;
    logic         resume;
    logic [W-1:0] next_pc;
    logic [W-1:0] pc;
    logic [W-1:0] pc_inc;
    logic [1:0]   bm_select;
    logic         beq;
    logic         bneq;
    logic         ir_load;
    logic         pc_write;
    logic         busy;
    logic         halted;
    logic [W-1:0] retired_count;

    pc_sequencer #(.DATA_WIDTH(W), .RESET_VECTOR(RV)) dut (
        .clk(clk), .reset_n(reset_n), .opcode(opcode), .mem_ready(mem_ready),
        .halt_req(halt_req), .resume(resume), .next_pc(next_pc), .pc(pc),
        .pc_inc(pc_inc), .bm_select(bm_select), .beq(beq), .bneq(bneq),
        .ir_load(ir_load), .pc_write(pc_write), .busy(busy), .halted(halted),
        .retired_count(retired_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]   sel;
        logic         b;
        logic         bn;
        logic [W-1:0] pc;
        logic [W-1:0] rc;
        logic [W-1:0] inc;
    } exp_t;

    exp_t         sb_q[$];
    exp_t         mon_e;
    int           tests = 0;
    int           fails = 0;
    logic [W-1:0] pc_m;
    logic [W-1:0] rc_m;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: each pc_write pulse is matched against the oldest expectation.
    always begin
        @(negedge clk);
        if (pc_write === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("pc_write_unexpected", {31'd0, pc_write}, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check("bm_select", {30'd0, bm_select}, {30'd0, mon_e.sel});
                check("beq", {31'd0, beq}, {31'd0, mon_e.b});
                check("bneq", {31'd0, bneq}, {31'd0, mon_e.bn});
                @(posedge clk);
                #1;
                check("pc_after", {20'd0, pc}, {20'd0, mon_e.pc});
                check("retired_after", {20'd0, retired_count}, {20'd0, mon_e.rc});
                check("pc_inc", {20'd0, pc_inc}, {20'd0, mon_e.inc});
            end
        end
    end

    // Issue one instruction from FETCH; returns at the FETCH (or HALTED) negedge.
    task automatic run_instr(input logic [5:0] op, input logic [W-1:0] npc,
                             input logic [1:0] sel, input logic b, input logic bn,
                             input logic hreq);
        logic [W-1:0] inc_v;
        opcode    = op;
        next_pc   = npc;
        mem_ready = 1'b1;
        rc_m      = rc_m + 12'd1;
        pc_m      = npc;
        inc_v     = npc + 12'd1;
        sb_q.push_back('{sel: sel, b: b, bn: bn, pc: npc, rc: rc_m, inc: inc_v});
        #1;
        check("ir_load_fetch", {31'd0, ir_load}, 32'd1);
        @(negedge clk);
        check("ir_load_decode", {31'd0, ir_load}, 32'd0);
        check("pc_write_decode", {31'd0, pc_write}, 32'd0);
        if (hreq) halt_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        halt_req = 1'b0;
    endtask

    initial begin
        reset_n   = 1'b0;
        opcode    = 6'h00;
        mem_ready = 1'b1;
        halt_req  = 1'b0;
        resume    = 1'b0;
        next_pc   = 12'h000;
        pc_m      = RV;
        rc_m      = 12'd0;

        // Reset state, with mem_ready high to show ir_load is held off.
        repeat (2) @(negedge clk);
        check("rst_pc", {20'd0, pc}, {20'd0, RV});
        check("rst_rc", {20'd0, retired_count}, 32'd0);
        check("rst_ir_load", {31'd0, ir_load}, 32'd0);
        check("rst_pc_write", {31'd0, pc_write}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_bm_select", {30'd0, bm_select}, 32'd0);
        check("rst_beq_bneq", {30'd0, beq, bneq}, 32'd0);

        // Sequential instruction straight out of reset: 3 cycles to the PC update.
        reset_n = 1'b1;
        run_instr(6'h00, 12'h001, 2'b00, 1'b0, 1'b0, 1'b0);
        // Branch-equal, branch-not-equal, jump, jump-register.
        run_instr(6'h04, 12'h040, 2'b01, 1'b1, 1'b0, 1'b0);
        run_instr(6'h05, 12'h048, 2'b01, 1'b0, 1'b1, 1'b0);
        run_instr(6'h02, 12'h200, 2'b10, 1'b0, 1'b0, 1'b0);
        run_instr(6'h08, 12'h300, 2'b11, 1'b0, 1'b0, 1'b0);

        // Memory stall: FETCH holds; halt_req and resume are ignored here.
        mem_ready = 1'b0;
        halt_req  = 1'b1;
        resume    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_ir_load", {31'd0, ir_load}, 32'd0);
            check("stall_busy_halted", {30'd0, busy, halted}, 32'd2);
            check("stall_pc", {20'd0, pc}, {20'd0, pc_m});
        end
        halt_req = 1'b0;
        resume   = 1'b0;
        run_instr(6'h00, 12'h033, 2'b00, 1'b0, 1'b0, 1'b0);

        // Halt opcode at pc=0x10.
        run_instr(6'h02, 12'h010, 2'b10, 1'b0, 1'b0, 1'b0);
        opcode = 6'h3F;
        #1;
        check("halt_ir_load", {31'd0, ir_load}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        check("halt_exec_pc_write", {31'd0, pc_write}, 32'd0);
        check("halt_exec_bm_select", {30'd0, bm_select}, 32'd0);
        check("halt_exec_busy", {31'd0, busy}, 32'd1);
        rc_m = rc_m + 12'd1;
        @(negedge clk);
        mem_ready = 1'b0;
        check("halt_halted", {31'd0, halted}, 32'd1);
        check("halt_busy", {31'd0, busy}, 32'd0);
        check("halt_pc", {20'd0, pc}, 32'h010);
        check("halt_rc", {20'd0, retired_count}, {20'd0, rc_m});
        @(negedge clk);
        check("halt_stays", {31'd0, halted}, 32'd1);
        resume = 1'b1;
        @(negedge clk);
        resume = 1'b0;
        check("resume_halted", {31'd0, halted}, 32'd0);
        check("resume_busy", {31'd0, busy}, 32'd1);
        check("resume_pc", {20'd0, pc}, 32'h010);

        // halt_req raised during DECODE takes effect after EXECUTE.
        run_instr(6'h00, 12'h022, 2'b00, 1'b0, 1'b0, 1'b1);
        mem_ready = 1'b0;
        check("hreq_halted", {31'd0, halted}, 32'd1);
        check("hreq_pc", {20'd0, pc}, 32'h022);
        resume = 1'b1;
        @(negedge clk);
        resume = 1'b0;
        check("hreq_resume", {30'd0, busy, halted}, 32'd2);

        // Reset landing on EXECUTE with pc=0x20 suppresses that retire.
        run_instr(6'h02, 12'h020, 2'b10, 1'b0, 1'b0, 1'b0);
        opcode  = 6'h00;
        next_pc = 12'h055;
        @(negedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(negedge clk);
        check("rst_exec_pc_write", {31'd0, pc_write}, 32'd0);
        check("rst_exec_pc_hold", {20'd0, pc}, 32'h020);
        @(negedge clk);
        check("rst_exec_pc", {20'd0, pc}, {20'd0, RV});
        check("rst_exec_rc", {20'd0, retired_count}, 32'd0);
        check("rst_exec_state", {30'd0, busy, halted}, 32'd2);
        check("rst_exec_ir_load", {31'd0, ir_load}, 32'd0);
        pc_m    = RV;
        rc_m    = 12'd0;
        reset_n = 1'b1;

        // Retired counter wraps from all-ones to zero; pc_inc wraps too.
        for (int i = 0; i < 4095; i++) begin
            run_instr(6'h01, W'(i), 2'b00, 1'b0, 1'b0, 1'b0);
        end
        check("rc_all_ones", {20'd0, retired_count}, 32'hFFF);
        run_instr(6'h00, 12'hFFF, 2'b00, 1'b0, 1'b0, 1'b0);
        mem_ready = 1'b0;
        @(negedge clk);
        check("rc_wrap", {20'd0, retired_count}, 32'd0);
        check("pc_inc_wrap", {20'd0, pc_inc}, 32'd0);

        check("sb_drain", sb_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter DATA_WIDTH SHALL default to 32 and set the width of the PC, next-PC and retired-count buses.
REQ-002 Parameter RESET_VECTOR SHALL default to 0 and set the PC value loaded at reset.
REQ-003 Port clk SHALL be a 1-bit input clock; all state changes occur on its rising edge.
REQ-004 Port reset_n SHALL be a 1-bit input, synchronous and active-low: the block resets on a rising clk edge where reset_n=0.
REQ-005 Port opcode SHALL be a 6-bit input holding the opcode of the instruction register, sampled in DECODE.
REQ-006 Port mem_ready SHALL be a 1-bit input: instruction memory data valid.
REQ-007 Port halt_req SHALL be a 1-bit input requesting an external halt.
REQ-008 Port resume SHALL be a 1-bit input that releases HALTED.
REQ-009 Port next_pc SHALL be a DATA_WIDTH input carrying the next-PC mux output.
REQ-010 Port pc SHALL be a DATA_WIDTH output carrying the registered program counter.
REQ-011 Port pc_inc SHALL be a DATA_WIDTH output equal to pc+1 (combinational, modulo 2^DATA_WIDTH).
REQ-012 Port bm_select SHALL be a 2-bit output selecting the next-PC source: 00 sequential, 01 branch, 10 jump, 11 jump-register.
REQ-013 Ports beq and bneq SHALL be 1-bit outputs carrying the branch-type flags to the next-PC mux.
REQ-014 Ports ir_load, pc_write, busy and halted SHALL be 1-bit outputs; retired_count SHALL be a DATA_WIDTH output.

Function
REQ-015 The FSM SHALL have the states FETCH, DECODE, EXECUTE and HALTED.
REQ-016 In FETCH, if mem_ready=1, the block SHALL assert ir_load for that cycle and move to DECODE; otherwise it SHALL stay in FETCH with ir_load=0.
REQ-017 In DECODE, the block SHALL register the opcode class and move to EXECUTE on the next edge, taking exactly 1 cycle.
REQ-018 Opcode decode SHALL be: 6'h04 branch-equal; 6'h05 branch-not-equal; 6'h02 jump; 6'h08 jump-register; 6'h3F halt; all other values sequential.
REQ-019 In EXECUTE, the block SHALL drive the outputs below and assert pc_write=1 for exactly one cycle.
- bm_select: 01 for branch-equal and branch-not-equal, 10 for jump, 11 for jump-register, 00 for sequential.
- beq=1 only for branch-equal; bneq=1 only for branch-not-equal.
REQ-020 On an EXECUTE edge with pc_write=1, the block SHALL load next_pc into pc and increment retired_count by 1, wrapping to 0 after all-ones.
REQ-021 After EXECUTE, the block SHALL go to HALTED if halt_req=1; otherwise it SHALL go to FETCH.
REQ-022 A halt opcode in EXECUTE SHALL assert pc_write=0, leave pc unchanged, increment retired_count, and go to HALTED.
REQ-023 halt_req SHALL be honoured only at the EXECUTE-to-next boundary; in other states it SHALL have no effect.
REQ-024 If halt_req=1 and the opcode is halt in the same EXECUTE cycle, the block SHALL take the halt-opcode behaviour once, with no double count.
REQ-025 In HALTED, halted=1 and pc_write=0; resume=1 SHALL move the block to FETCH on the next edge with pc unchanged.
REQ-026 resume SHALL be ignored in every state other than HALTED.
REQ-027 Outside EXECUTE, the block SHALL hold bm_select=00, beq=0, bneq=0 and pc_write=0.
REQ-028 busy SHALL be 1 in FETCH, DECODE and EXECUTE, and 0 in HALTED.
REQ-029 A sequential instruction with mem_ready already high SHALL take exactly 3 cycles from entering FETCH to the pc update.

Reset
REQ-030 While reset_n=0 at a clk edge, from any state, the block SHALL set state to FETCH, pc to RESET_VECTOR and retired_count to 0.
REQ-031 While reset_n=0, ir_load, pc_write, beq, bneq and halted SHALL be 0 and bm_select SHALL be 00.
REQ-032 On the first edge with reset_n=1, the block SHALL begin FETCH normally.
REQ-033 A reset asserted during EXECUTE SHALL suppress that cycle's pc and retired_count update.

Verification
REQ-034 Reset then opcode 6'h00, mem_ready=1, next_pc=1 -> ir_load in cycle 1, pc_write in cycle 3, pc=1, retired_count=1.
REQ-035 Opcode 6'h04 -> in EXECUTE bm_select=01, beq=1, bneq=0; next_pc=0x40 -> pc=0x40. Opcode 6'h05 -> bneq=1, beq=0.
REQ-036 Opcodes 6'h02 and 6'h08 -> bm_select=10 and 11 respectively in EXECUTE; pc takes next_pc; beq=bneq=0.
REQ-037 mem_ready held 0 for 5 cycles in FETCH -> ir_load=0, state stays FETCH, pc stable; pc advances 3 cycles after mem_ready rises.
REQ-038 Opcode 6'h3F with pc=0x10 -> halted=1, pc=0x10, retired_count+1; resume pulse -> FETCH next edge; halt_req raised in DECODE -> halted after EXECUTE.
REQ-039 reset_n=0 in EXECUTE with pc=0x20 and RESET_VECTOR=0x100 -> pc=0x100, retired_count=0, state FETCH; retired_count all-ones plus 1 retire -> 0.
